// File: rtl/usb_dev_out_responder_if.sv
// Bundles the decoded-packet input, handshake output and memory write port
// of the USB OUT responder into one interface.
interface usb_dev_out_responder_if;
  logic        pkt_valid;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_addr;
  logic [3:0]  pkt_endp;
  logic [63:0] pkt_data;
  logic        pkt_crc_ok;
  logic        hs_valid;
  logic [3:0]  hs_pid;
  logic        hs_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        err_no_addr;

  modport slave (
    input  pkt_valid, pkt_pid, pkt_addr, pkt_endp, pkt_data, pkt_crc_ok, hs_ready,
    output hs_valid, hs_pid, mem_we, mem_addr, mem_wdata, err_no_addr
  );

  modport master (
    output pkt_valid, pkt_pid, pkt_addr, pkt_endp, pkt_data, pkt_crc_ok, hs_ready,
    input  hs_valid, hs_pid, mem_we, mem_addr, mem_wdata, err_no_addr
  );
endinterface

// File: rtl/usb_dev_out_responder.sv
// Device-side USB OUT responder: pairs OUT tokens with DATA packets, answers
// ACK/NAK, tracks per-endpoint toggles and issues address+data memory writes.
module usb_dev_out_responder #(
  parameter logic [6:0]  DEV_ADDR  = 7'd5,
  parameter logic [3:0]  ADDR_ENDP = 4'd4,
  parameter logic [3:0]  DATA_ENDP = 4'd8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  usb_dev_out_responder_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, SEND_HS} state_t;

  state_t      state, state_next;
  logic        ep_data_q;
  logic        tog_addr_q, tog_data_q;
  logic        addr_valid_q;
  logic [TW-1:0] timer_q;
  logic [15:0] addr_q;
  logic [3:0]  hs_pid_q, hs_pid_next;
  logic        mem_we_q, err_q;
  logic [15:0] mem_addr_q;
  logic [63:0] mem_wdata_q;

  logic token_ok, is_data, exp_tog, tog_match;
  logic latch, commit;

  always_comb begin
    token_ok  = bus.pkt_valid && (bus.pkt_pid == PID_OUT) && bus.pkt_crc_ok &&
                (bus.pkt_addr == DEV_ADDR) &&
                ((bus.pkt_endp == ADDR_ENDP) || (bus.pkt_endp == DATA_ENDP));
    is_data   = bus.pkt_valid && ((bus.pkt_pid == PID_DATA0) || (bus.pkt_pid == PID_DATA1));
    exp_tog   = ep_data_q ? tog_data_q : tog_addr_q;
    tog_match = ((bus.pkt_pid == PID_DATA1) == exp_tog);
  end

  // A fresh token always wins in WAIT_DATA; a DATA packet on the last timer
  // cycle still beats the timeout.
  always_comb begin
    state_next  = state;
    hs_pid_next = hs_pid_q;
    latch       = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (token_ok) begin
          latch      = 1'b1;
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (token_ok) begin
          latch = 1'b1;
        end else if (is_data) begin
          state_next = SEND_HS;
          if (!bus.pkt_crc_ok) begin
            hs_pid_next = PID_NAK;
          end else begin
            hs_pid_next = PID_ACK;
            commit      = tog_match;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_next = IDLE;
        end
      end
      SEND_HS: begin
        if (bus.hs_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ep_data_q    <= 1'b0;
      tog_addr_q   <= 1'b0;
      tog_data_q   <= 1'b0;
      addr_valid_q <= 1'b0;
      timer_q      <= '0;
      addr_q       <= '0;
      hs_pid_q     <= '0;
      mem_we_q     <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state    <= state_next;
      hs_pid_q <= hs_pid_next;
      mem_we_q <= 1'b0;
      err_q    <= 1'b0;
      if (latch) begin
        ep_data_q <= (bus.pkt_endp == DATA_ENDP);
        timer_q   <= '0;
      end else if (state == WAIT_DATA && timer_q != TIMER_LAST) begin
        timer_q <= timer_q + 1'b1;
      end
      // The write fires only once both the address and data phases have landed.
      if (commit) begin
        if (!ep_data_q) begin
          tog_addr_q   <= ~tog_addr_q;
          addr_q       <= bus.pkt_data[15:0];
          addr_valid_q <= 1'b1;
        end else begin
          tog_data_q <= ~tog_data_q;
          if (addr_valid_q) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= addr_q;
            mem_wdata_q  <= bus.pkt_data;
            addr_valid_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.hs_valid    = (state == SEND_HS);
  assign bus.hs_pid      = hs_pid_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.err_no_addr = err_q;
endmodule
